// File: rtl/player_ctl_pkg.sv
// Shared types and screen constants for the player motion controller.
package player_ctl_pkg;

    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;
    localparam int SPRITE_W = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2
    } State;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;

endpackage

// File: rtl/player_ctl_if.sv
// Button/vblank inputs and sprite position/state outputs of player_ctl.
interface player_ctl_if;
    import player_ctl_pkg::*;

    logic        vblnk;
    logic        btn_left;
    logic        btn_right;
    logic        btn_jump;
    logic [11:0] xpos_player;
    logic [11:0] ypos_player;
    State        state;
    logic        airborne;

    modport master (
        output vblnk, btn_left, btn_right, btn_jump,
        input  xpos_player, ypos_player, state, airborne
    );

    modport slave (
        input  vblnk, btn_left, btn_right, btn_jump,
        output xpos_player, ypos_player, state, airborne
    );

endinterface

// File: rtl/player_ctl_frame_tick.sv
// One-cycle pulse per rising edge of vblnk; history resets high so a vblnk
// already asserted at reset release does not fire.
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vblnk_i,
    output logic tick_o
);

    logic vblnk_q, vblnk_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q      <= 1'b1;
            vblnk_prev_q <= 1'b1;
        end else begin
            vblnk_q      <= vblnk_i;
            vblnk_prev_q <= vblnk_q;
        end
    end

    assign tick_o = vblnk_q & ~vblnk_prev_q;

endmodule

// File: rtl/player_ctl.sv
// Per-frame walk and gravity jump controller feeding draw_player.
module player_ctl
    import player_ctl_pkg::*;
#(
    parameter int         X_START  = 0,
    parameter int         X_MIN    = 0,
    parameter int         X_MAX    = SCREEN_W - SPRITE_W,
    parameter int         Y_GROUND = 420,
    parameter int         STEP_X   = 4,
    parameter logic [7:0] JUMP_V   = 8'd16,
    parameter logic [7:0] GRAVITY  = 8'd1
) (
    input  logic          clk,
    input  logic          rst,
    player_ctl_if.slave   pif
);

    localparam logic [12:0] X_MAX13      = 13'(X_MAX);
    localparam logic [12:0] X_LEFT_LIM13 = 13'(X_MIN + STEP_X);
    localparam logic [12:0] Y_GROUND13   = 13'(Y_GROUND);

    logic tick;

    frame_tick u_tick (
        .clk     (clk),
        .rst     (rst),
        .vblnk_i (pif.vblnk),
        .tick_o  (tick)
    );

    State        state_q, state_d;
    jump_state_t jst_q, jst_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [7:0]  vy_q, vy_d;
    logic        airborne_q;

    logic [12:0] x_right;
    logic [8:0]  vy_sum;
    logic [7:0]  vn;
    logic [12:0] y_fall;

    always_comb begin
        x_right = {1'b0, x_q} + 13'(STEP_X);
        vy_sum  = {1'b0, vy_q} + {1'b0, GRAVITY};
        vn      = vy_sum[8] ? 8'hFF : vy_sum[7:0];
        y_fall  = {1'b0, y_q} + {5'b0, vn};
    end

    // Walk FSM: direction decided purely by the buttons seen on the tick.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        if (tick) begin
            if (pif.btn_right && !pif.btn_left) begin
                state_d = RIGHT;
                x_d     = (x_right > X_MAX13) ? 12'(X_MAX) : x_right[11:0];
            end else if (pif.btn_left && !pif.btn_right) begin
                state_d = LEFT;
                x_d     = ({1'b0, x_q} < X_LEFT_LIM13) ? 12'(X_MIN)
                                                        : x_q - 12'(STEP_X);
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Jump FSM: landing tick returns to GROUND; a relaunch needs a later tick.
    always_comb begin
        jst_d = jst_q;
        y_d   = y_q;
        vy_d  = vy_q;
        if (tick) begin
            unique case (jst_q)
                GROUND: begin
                    if (pif.btn_jump) begin
                        vy_d  = JUMP_V;
                        jst_d = RISE;
                    end
                end
                RISE: begin
                    y_d = (y_q < {4'b0, vy_q}) ? 12'd0 : y_q - {4'b0, vy_q};
                    if (vy_q <= GRAVITY) begin
                        vy_d  = 8'd0;
                        jst_d = FALL;
                    end else begin
                        vy_d  = vy_q - GRAVITY;
                    end
                end
                FALL: begin
                    if (y_fall >= Y_GROUND13) begin
                        y_d   = 12'(Y_GROUND);
                        vy_d  = 8'd0;
                        jst_d = GROUND;
                    end else begin
                        y_d   = y_fall[11:0];
                        vy_d  = vn;
                    end
                end
                default: begin
                    jst_d = GROUND;
                    vy_d  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            jst_q      <= GROUND;
            x_q        <= 12'(X_START);
            y_q        <= 12'(Y_GROUND);
            vy_q       <= 8'd0;
            airborne_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            jst_q      <= jst_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            airborne_q <= (jst_d != GROUND);
        end
    end

    assign pif.xpos_player = x_q;
    assign pif.ypos_player = y_q;
    assign pif.state       = state_q;
    assign pif.airborne    = airborne_q;

endmodule

// File: tb/tb_player_ctl.sv
// Directed checks for player_ctl: walk table plus jump/reset/timing sequences.
module tb_player_ctl;
    import player_ctl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic vblnk, bl, br, bj;

    always #5 clk = ~clk;

    player_ctl_if a_if ();
    player_ctl_if b_if ();

    assign a_if.vblnk     = vblnk;
    assign a_if.btn_left  = bl;
    assign a_if.btn_right = br;
    assign a_if.btn_jump  = bj;
    assign b_if.vblnk     = vblnk;
    assign b_if.btn_left  = bl;
    assign b_if.btn_right = br;
    assign b_if.btn_jump  = bj;

    player_ctl u_dut (
        .clk (clk),
        .rst (rst),
        .pif (a_if.slave)
    );

    player_ctl #(.X_START(980)) u_clamp (
        .clk (clk),
        .rst (rst),
        .pif (b_if.slave)
    );

    typedef struct {
        logic l, r, j;
        int   x, xc, y;
        State st;
        logic air;
    } vec_t;

    vec_t tbl[15];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input int x, input int y,
                           input State st, input logic air);
        chk({nm, " x"}, int'(a_if.xpos_player), x);
        chk({nm, " y"}, int'(a_if.ypos_player), y);
        chk({nm, " state"}, int'(a_if.state), int'(st));
        chk({nm, " air"}, int'(a_if.airborne), int'(air));
    endtask

    task automatic do_tick();
        @(negedge clk) vblnk = 1'b1;
        repeat (3) @(negedge clk);
        vblnk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_btn(input logic l, input logic r, input logic j);
        bl = l; br = r; bj = j;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b0, 1'b1, 1'b0, 4 * (i + 1), (i == 0) ? 980 : 984, 420, RIGHT, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 40, 984, 420, IDLE,  1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 40, 984, 420, IDLE,  1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 36, 980, 420, LEFT,  1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 40, 984, 420, RIGHT, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 40, 984, 420, IDLE,  1'b0};

        // Reset, released with vblnk already high and right held.
        rst = 1'b1; vblnk = 1'b0; set_btn(0, 0, 0);
        repeat (3) @(negedge clk);
        vblnk = 1'b1; br = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk_all("reset", 0, 420, IDLE, 1'b0);
        chk("reset xc", int'(b_if.xpos_player), 980);
        repeat (4) @(negedge clk);
        vblnk = 1'b0;
        repeat (2) @(negedge clk);
        chk("no tick at release x", int'(a_if.xpos_player), 0);
        chk("no tick at release state", int'(a_if.state), int'(IDLE));

        // Update lands one edge after vblnk is first sampled high.
        set_btn(1, 0, 0);
        @(negedge clk) vblnk = 1'b1;
        @(negedge clk);
        chk("latency edge N state", int'(a_if.state), int'(IDLE));
        @(negedge clk);
        chk("latency edge N+1 state", int'(a_if.state), int'(LEFT));
        chk("left clamp x", int'(a_if.xpos_player), 0);
        chk("latency xc", int'(b_if.xpos_player), 976);
        repeat (6) @(negedge clk);
        chk("one tick per pulse xc", int'(b_if.xpos_player), 976);
        vblnk = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            set_btn(tbl[i].l, tbl[i].r, tbl[i].j);
            do_tick();
            chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].st, tbl[i].air);
            chk($sformatf("vec%0d xc", i), int'(b_if.xpos_player), tbl[i].xc);
        end

        // Buttons wiggling with vblnk low must not move anything.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_btn(i[0], i[1], i[2]);
        end
        @(negedge clk);
        chk_all("midframe", 40, 420, IDLE, 1'b0);

        // Single jump tap with left held throughout.
        set_btn(1, 0, 1);
        do_tick();
        chk_all("launch", 36, 420, LEFT, 1'b1);
        bj = 1'b0;
        do_tick();
        chk_all("rise1", 32, 404, LEFT, 1'b1);
        for (int t = 2; t <= 16; t++) do_tick();
        chk_all("apex", 0, 284, LEFT, 1'b1);
        for (int t = 17; t <= 31; t++) do_tick();
        chk_all("fall31", 0, 404, LEFT, 1'b1);
        do_tick();
        chk_all("land32", 0, 420, LEFT, 1'b0);
        do_tick();
        chk_all("ground33", 0, 420, LEFT, 1'b0);

        // Held jump: land, one ground-y tick, then relaunch.
        set_btn(0, 0, 1);
        do_tick();
        chk_all("held launch", 0, 420, IDLE, 1'b1);
        for (int t = 1; t <= 31; t++) do_tick();
        chk_all("held fall31", 0, 404, IDLE, 1'b1);
        do_tick();
        chk_all("held land", 0, 420, IDLE, 1'b0);
        do_tick();
        chk_all("relaunch", 0, 420, IDLE, 1'b1);
        do_tick();
        chk_all("relaunch rise1", 0, 404, IDLE, 1'b1);

        // Reset mid-rise.
        set_btn(0, 1, 0);
        do_tick();
        chk("rise2 y", int'(a_if.ypos_player), 389);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk_all("midrise reset", 0, 420, IDLE, 1'b0);
        chk("midrise reset xc", int'(b_if.xpos_player), 980);
        do_tick();
        chk_all("post reset tick", 4, 420, RIGHT, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
